// File: rtl/ext_rx_axis_bridge.sv
// Receive-side P2P bridge: external stream -> AXIS with FIFO buffering, keep-framing checks and tuser metadata.
// Optional per-packet statistics outputs are enabled by defining EXT_RX_STATS_EN.
package bus_interfaces_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } external_m2s_t;

    typedef struct packed {
        logic ready;
    } external_s2m_t;

    typedef struct packed {
        logic        tvalid;
        logic [63:0] tdata;
        logic [7:0]  tkeep;
        logic [63:0] tuser;
        logic        tlast;
    } axis_m2s_t;

    typedef struct packed {
        logic tready;
    } axis_s2m_t;
endpackage

module ext_rx_axis_bridge
    import bus_interfaces_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SEQ_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  external_m2s_t ext_in,
    output external_s2m_t ext_out,
    output axis_m2s_t     axis_out,
    input  axis_s2m_t     axis_in
`ifdef EXT_RX_STATS_EN
    ,
    output logic [31:0]   pkt_cnt,
    output logic [31:0]   err_pkt_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic [63:0] tuser;
        logic        last;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           new_entry;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             full, empty, push, pop;

    state_t           state, state_d;
    logic [SEQ_W-1:0] seq;
    logic [15:0]      byte_cnt, cur_bytes;
    logic             err, cur_err, frame_err, tail_ok;
    logic [3:0]       keep_ones;
    logic [16:0]      byte_sum;
    logic [7:0]       keep_p1;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign push  = ext_in.valid && ext_out.ready;
    assign pop   = axis_out.tvalid && axis_in.tready;

    always_comb begin
        ext_out       = '0;
        ext_out.ready = !full && !rst;
    end

    // A legal tail keep is a contiguous run of ones from bit 0: adding one clears every set bit.
    always_comb begin
        keep_ones = '0;
        for (int i = 0; i < 8; i++) keep_ones = keep_ones + {3'b000, ext_in.keep[i]};
        byte_sum  = {1'b0, byte_cnt} + {13'b0, keep_ones};
        cur_bytes = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];
        keep_p1   = ext_in.keep + 8'd1;
        tail_ok   = (ext_in.keep != 8'h00) && ((keep_p1 & ext_in.keep) == 8'h00);
        frame_err = ext_in.last ? !tail_ok : (ext_in.keep != 8'hFF);
        cur_err   = err || frame_err;

        new_entry             = '0;
        new_entry.data        = ext_in.data;
        new_entry.keep        = ext_in.keep;
        new_entry.last        = ext_in.last;
        new_entry.tuser[SEQ_W-1:0] = seq;
        if (ext_in.last) begin
            new_entry.tuser[31:16] = cur_bytes;
            new_entry.tuser[32]    = cur_err;
        end
    end

    always_comb begin
        state_d = state;
        if (push) state_d = ext_in.last ? IDLE : IN_PKT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            seq      <= '0;
            byte_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_d;
            if (push) begin
                if (ext_in.last) begin
                    seq      <= seq + SEQ_W'(1);
                    byte_cnt <= '0;
                    err      <= 1'b0;
                end else begin
                    byte_cnt <= cur_bytes;
                    err      <= cur_err;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= new_entry;
    end

    // Payload is forced to zero while empty so stale storage never shows on the bus.
    always_comb begin
        axis_out = '0;
        if (!empty) begin
            axis_out.tvalid = 1'b1;
            axis_out.tdata  = mem[rd_ptr].data;
            axis_out.tkeep  = mem[rd_ptr].keep;
            axis_out.tuser  = mem[rd_ptr].tuser;
            axis_out.tlast  = mem[rd_ptr].last;
        end
    end

`ifdef EXT_RX_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt     <= '0;
            err_pkt_cnt <= '0;
        end else if (push && ext_in.last) begin
            pkt_cnt <= pkt_cnt + 32'd1;
            if (cur_err) err_pkt_cnt <= err_pkt_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ext_rx_axis_bridge.sv
// Directed self-checking bench for ext_rx_axis_bridge (default instance plus a SEQ_W=2 instance).
module tb_ext_rx_axis_bridge;
    import bus_interfaces_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    external_m2s_t ext_in, ext2_in;
    external_s2m_t ext_out, ext2_out;
    axis_m2s_t     axis_out, axis2_out;
    axis_s2m_t     axis_in, axis2_in;
`ifdef EXT_RX_STATS_EN
    logic [31:0]   pkt_cnt, err_pkt_cnt, pkt_cnt2, err_pkt_cnt2;
`endif

    int tests = 0;
    int fails = 0;

    logic [63:0] rx_data [8];
    logic [63:0] last_tuser;
    logic        last_tlast;
    int          rx_n;
    int          idx_in;
    logic        acc;

    always #5 clk = ~clk;

    ext_rx_axis_bridge #(.DEPTH(4), .SEQ_W(16)) u_dut (
        .clk(clk), .rst(rst), .ext_in(ext_in), .ext_out(ext_out),
        .axis_out(axis_out), .axis_in(axis_in)
`ifdef EXT_RX_STATS_EN
        , .pkt_cnt(pkt_cnt), .err_pkt_cnt(err_pkt_cnt)
`endif
    );

    ext_rx_axis_bridge #(.DEPTH(4), .SEQ_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .ext_in(ext2_in), .ext_out(ext2_out),
        .axis_out(axis2_out), .axis_in(axis2_in)
`ifdef EXT_RX_STATS_EN
        , .pkt_cnt(pkt_cnt2), .err_pkt_cnt(err_pkt_cnt2)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [63:0] d, input logic [7:0] k, input logic l);
        ext_in.valid = v;
        ext_in.data  = d;
        ext_in.keep  = k;
        ext_in.last  = l;
        step();
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        ext_in   = '0;
        ext2_in  = '0;
        axis_in  = '{tready: 1'b1};
        axis2_in = '{tready: 1'b1};

        // Reset state
        #2;
        checkOutput("rst_ready", 64'(ext_out.ready), 64'd0);
        checkOutput("rst_axis_zero", 64'(axis_out != '0), 64'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        checkOutput("post_rst_ready", 64'(ext_out.ready), 64'd1);
        checkOutput("post_rst_state", 64'(u_dut.state), 64'd0);

        // 3-beat packet FF,FF,0F
        applyStimulus(1'b1, 64'hA1A1_0000_0000_0001, 8'hFF, 1'b0);
        checkOutput("p1_b1_valid", 64'(axis_out.tvalid), 64'd1);
        checkOutput("p1_b1_data", axis_out.tdata, 64'hA1A1_0000_0000_0001);
        checkOutput("p1_b1_tuser", axis_out.tuser, 64'd0);
        checkOutput("p1_state_inpkt", 64'(u_dut.state), 64'd1);
        applyStimulus(1'b1, 64'hA2A2_0000_0000_0002, 8'hFF, 1'b0);
        checkOutput("p1_b2_data", axis_out.tdata, 64'hA2A2_0000_0000_0002);
        checkOutput("p1_b2_tlast", 64'(axis_out.tlast), 64'd0);
        applyStimulus(1'b1, 64'hA3A3_0000_0000_0003, 8'h0F, 1'b1);
        checkOutput("p1_b3_data", axis_out.tdata, 64'hA3A3_0000_0000_0003);
        checkOutput("p1_b3_tlast", 64'(axis_out.tlast), 64'd1);
        checkOutput("p1_b3_tuser", axis_out.tuser, 64'h0000_0000_0014_0000);
        applyStimulus(1'b0, 64'd0, 8'h00, 1'b0);
        checkOutput("p1_drained", 64'(axis_out.tvalid), 64'd0);
        applyStimulus(1'b1, 64'hB0B0_0000_0000_0010, 8'hFF, 1'b1);
        checkOutput("p2_seq1_tuser", axis_out.tuser, 64'h0000_0000_0008_0001);
        applyStimulus(1'b0, 64'd0, 8'h00, 1'b0);

        // Backpressure: 6 beats offered while tready=0
        axis_in.tready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 64'hC000_0000_0000_0000 + 64'(i), 8'hFF, 1'b0);
        checkOutput("bp_ready_low", 64'(ext_out.ready), 64'd0);
        checkOutput("bp_head_data", axis_out.tdata, 64'hC000_0000_0000_0000);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 64'hC000_0000_0000_0004, 8'hFF, 1'b0);
        checkOutput("bp_ready_still_low", 64'(ext_out.ready), 64'd0);
        checkOutput("bp_head_stable", axis_out.tdata, 64'hC000_0000_0000_0000);
        checkOutput("bp_valid_stable", 64'(axis_out.tvalid), 64'd1);

        axis_in.tready = 1'b1;
        rx_n   = 0;
        idx_in = 4;
        last_tuser = '0;
        last_tlast = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (axis_out.tvalid) begin
                if (rx_n < 8) rx_data[rx_n] = axis_out.tdata;
                last_tuser = axis_out.tuser;
                last_tlast = axis_out.tlast;
                rx_n++;
            end
            if (idx_in < 6) begin
                ext_in.valid = 1'b1;
                ext_in.data  = 64'hC000_0000_0000_0000 + 64'(idx_in);
                ext_in.keep  = 8'hFF;
                ext_in.last  = (idx_in == 5);
                acc = ext_out.ready;
            end else begin
                ext_in = '0;
                acc = 1'b0;
            end
            step();
            if (acc) idx_in++;
        end
        checkOutput("bp_rx_count", 64'(rx_n), 64'd6);
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("bp_rx_order_%0d", i), rx_data[i], 64'hC000_0000_0000_0000 + 64'(i));
        checkOutput("bp_last_tlast", 64'(last_tlast), 64'd1);
        checkOutput("bp_last_tuser", last_tuser, 64'h0000_0000_0030_0002);

        // Middle beat keep=7F marks the packet as errored
        applyStimulus(1'b1, 64'hD000_0000_0000_0001, 8'hFF, 1'b0);
        applyStimulus(1'b1, 64'hD000_0000_0000_0002, 8'h7F, 1'b0);
        checkOutput("err_mid_data", axis_out.tdata, 64'hD000_0000_0000_0002);
        checkOutput("err_mid_keep", 64'(axis_out.tkeep), 64'h7F);
        checkOutput("err_mid_tuser", axis_out.tuser, 64'h0000_0000_0000_0003);
        applyStimulus(1'b1, 64'hD000_0000_0000_0003, 8'hFF, 1'b1);
        checkOutput("err_last_tuser", axis_out.tuser, 64'h0000_0001_0017_0003);
`ifdef EXT_RX_STATS_EN
        checkOutput("stats_pkt_cnt", 64'(pkt_cnt), 64'd4);
        checkOutput("stats_err_cnt", 64'(err_pkt_cnt), 64'd1);
`endif
        applyStimulus(1'b0, 64'd0, 8'h00, 1'b0);

        // Single-beat packet with keep=00
        applyStimulus(1'b1, 64'hE000_0000_0000_0000, 8'h00, 1'b1);
        checkOutput("k0_tuser", axis_out.tuser, 64'h0000_0001_0000_0004);
        checkOutput("k0_state_idle", 64'(u_dut.state), 64'd0);
        checkOutput("k0_byte_cnt", 64'(u_dut.byte_cnt), 64'd0);
`ifdef EXT_RX_STATS_EN
        checkOutput("k0_err_cnt", 64'(err_pkt_cnt), 64'd2);
`endif
        applyStimulus(1'b0, 64'd0, 8'h00, 1'b0);

        // SEQ_W=2 wrap: 5 single-beat packets
        for (int i = 0; i < 5; i++) begin
            ext2_in.valid = 1'b1;
            ext2_in.data  = 64'hF000_0000_0000_0000 + 64'(i);
            ext2_in.keep  = 8'hFF;
            ext2_in.last  = 1'b1;
            step();
            checkOutput($sformatf("seq2_pkt_%0d", i), axis2_out.tuser, 64'h0000_0000_0008_0000 + 64'(i % 4));
        end
        ext2_in = '0;
        step();

        // Reset after 2 beats of a 4-beat packet
        applyStimulus(1'b1, 64'h1111_0000_0000_0001, 8'hFF, 1'b0);
        applyStimulus(1'b1, 64'h1111_0000_0000_0002, 8'hFF, 1'b0);
        checkOutput("mid_rst_pre_valid", 64'(axis_out.tvalid), 64'd1);
        ext_in = '0;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 64'(axis_out.tvalid), 64'd0);
        step();
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_axis_zero", 64'(axis_out != '0), 64'd0);
        checkOutput("mid_rst_seq", 64'(u_dut.seq), 64'd0);
        checkOutput("mid_rst_byte_cnt", 64'(u_dut.byte_cnt), 64'd0);
`ifdef EXT_RX_STATS_EN
        checkOutput("mid_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif
        applyStimulus(1'b1, 64'h1111_0000_0000_0003, 8'hFF, 1'b0);
        checkOutput("mid_rst_b3_data", axis_out.tdata, 64'h1111_0000_0000_0003);
        checkOutput("mid_rst_b3_tuser", axis_out.tuser, 64'd0);
        applyStimulus(1'b1, 64'h1111_0000_0000_0004, 8'hFF, 1'b1);
        checkOutput("mid_rst_b4_tuser", axis_out.tuser, 64'h0000_0000_0010_0000);
        applyStimulus(1'b0, 64'd0, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
